chunked_adder: RTL

//   Parametrised multi-cycle adder. Adds two WIDTH-bit operands plus carry-in.

---
 rtl/chunked_adder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/chunked_adder.sv
// ---------------------------------------------------------------------------
// chunked_adder
//   Multi-cycle adder: computes a + b + cin over WIDTH bits, CHUNK bits per
//   clock. A CHUNK-wide ripple adder is reused every cycle, and the carry is
//   held in a register between slices. The result appears NCHUNK cycles after
//   the edge that accepts start.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request a new addition (sampled only while busy == 0)
//   a      in   WIDTH  operand A, latched on the accept edge
//   b      in   WIDTH  operand B, latched on the accept edge
//   cin    in   1      carry-in, latched on the accept edge
//   busy   out  1      high while slices are being added
//   done   out  1      one-cycle pulse: sum/carry hold a new result
//   sum    out  WIDTH  registered (a + b + cin) mod 2^WIDTH
//   carry  out  1      registered carry-out of the MSB
// ---------------------------------------------------------------------------
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("chunked_adder: WIDTH must be >= 1 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    // Current slice operands and their CHUNK-bit ripple sum (carry in the MSB).
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK:0]   slice_sum;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        idx_d   = idx_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        carry_d = carry_q;

        slice_a   = CHUNK'(a_q >> (int'(idx_q) * CHUNK));
        slice_b   = CHUNK'(b_q >> (int'(idx_q) * CHUNK));
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, c_q};

        case (state_q)
            IDLE, DONE: begin
                // DONE accepts like IDLE so back-to-back requests see no bubble.
                if (start) begin
                    state_d = ADD;
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                psum_d[int'(idx_q)*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
                c_d   = slice_sum[CHUNK];
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Publish on the same edge that raises done; the outputs
                    // keep the previous result throughout ADD.
                    state_d = DONE;
                    sum_d   = psum_d;
                    carry_d = slice_sum[CHUNK];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign busy  = (state_q == ADD);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule
